// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell, a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             d_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] res_full;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d_bit       = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    assign res_full    = {d_bit, res_sr[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment before the case keeps this block free of
    // inferred latches on every path.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        borrow <= bin;
                        count  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_full;
                    borrow <= borrow_next;
                    if (count != LAST) begin
                        count <= count + CW'(1);
                    end else begin
                        // Last bit: publish the complete result in one step.
                        diff <= res_full;
                        bout <= borrow_next;
                        zero <= (res_full == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
